// File: rtl/branch_predictor_if.sv
// Bundles the IF-stage lookup, EXE-stage training and perf-counter signals
// exchanged between the pipeline controller and the branch predictor.
interface branch_predictor_if #(
   parameter int memAddrWidth = 15,
   parameter int CNT_W        = 32
);

   logic [memAddrWidth-1:0] IF_pc;
   logic                    BP_taken;
   logic [memAddrWidth-1:0] BP_target_pc;

   logic                    E_En;
   logic                    E_Branch_taken;
   logic [memAddrWidth-1:0] EXE_pc;
   logic [memAddrWidth-1:0] EXE_target_pc;
   logic                    Flush;
   logic                    Stall_MA;

   logic [CNT_W-1:0]        br_cnt;
   logic [CNT_W-1:0]        miss_cnt;

   // Pipeline side: presents PCs and branch resolutions, consumes predictions.
   modport master (
      output IF_pc,
      output E_En,
      output E_Branch_taken,
      output EXE_pc,
      output EXE_target_pc,
      output Flush,
      output Stall_MA,
      input  BP_taken,
      input  BP_target_pc,
      input  br_cnt,
      input  miss_cnt
   );

   // Predictor side: the mirror image of the pipeline view.
   modport slave (
      input  IF_pc,
      input  E_En,
      input  E_Branch_taken,
      input  EXE_pc,
      input  EXE_target_pc,
      input  Flush,
      input  Stall_MA,
      output BP_taken,
      output BP_target_pc,
      output br_cnt,
      output miss_cnt
   );

endinterface

// File: rtl/branch_predictor.sv
// IF-stage dynamic branch predictor: a direct-mapped branch target buffer
// with one 2-bit saturating direction counter per entry. Lookup is purely
// combinational on the IF PC; training happens on the clock edge from the
// branch resolution reported by EXE. Two saturating perf counters track
// resolved control-flow instructions and mispredict flushes.
module branch_predictor #(
   parameter int memAddrWidth = 15,
   parameter int ENTRIES      = 16,
   parameter int CNT_W        = 32
) (
   input  logic               clk,
   input  logic               rst,
   branch_predictor_if.slave  bus
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = memAddrWidth - IDX_W - 2;

   // Direction counter encoding: bit 1 is the predicted direction.
   localparam logic [1:0] CTR_STRONG_NT = 2'b00;
   localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
   localparam logic [1:0] CTR_WEAK_T    = 2'b10;
   localparam logic [1:0] CTR_STRONG_T  = 2'b11;

   logic [ENTRIES-1:0]      r_valid;
   logic [TAG_W-1:0]        r_tag    [ENTRIES];
   logic [memAddrWidth-1:0] r_target [ENTRIES];
   logic [1:0]              r_ctr    [ENTRIES];

   logic [CNT_W-1:0]        r_brCnt;
   logic [CNT_W-1:0]        r_missCnt;

   logic [IDX_W-1:0]        w_ridx;
   logic [TAG_W-1:0]        w_rtag;
   logic                    w_hit;
   logic                    w_bpTaken;
   logic [memAddrWidth-1:0] w_bpTarget;

   logic [IDX_W-1:0]        w_widx;
   logic [TAG_W-1:0]        w_wtag;
   logic                    w_whit;
   logic                    w_upd;
   logic [1:0]              w_ctrCur;
   logic [1:0]              w_ctrInc;
   logic [1:0]              w_ctrDec;

   logic                    w_unusedPcBits;

   // The two low PC bits are always zero for aligned instructions and never
   // take part in indexing or tag comparison.
   assign w_unusedPcBits = ^{bus.IF_pc[1:0], bus.EXE_pc[1:0]};

   assign w_ridx = bus.IF_pc[IDX_W+1:2];
   assign w_rtag = bus.IF_pc[memAddrWidth-1:IDX_W+2];

   assign w_widx = bus.EXE_pc[IDX_W+1:2];
   assign w_wtag = bus.EXE_pc[memAddrWidth-1:IDX_W+2];

   // Training only happens when EXE holds a control-flow instruction and the
   // memory stage is not stalled, so a held E_En trains exactly once.
   assign w_upd  = bus.E_En & ~bus.Stall_MA;

   // Lookup reads the registered table directly; a same-cycle write to the
   // same entry is not bypassed and becomes visible on the next cycle. The
   // reset term keeps the outputs quiet for the whole time reset is held.
   always_comb begin
      w_hit      = 1'b0;
      w_bpTaken  = 1'b0;
      w_bpTarget = '0;
      if (!rst && r_valid[w_ridx] && (r_tag[w_ridx] == w_rtag)) begin
         w_hit      = 1'b1;
         w_bpTaken  = r_ctr[w_ridx][1];
         w_bpTarget = r_target[w_ridx];
      end
   end

   assign bus.BP_taken     = w_bpTaken & w_hit;
   assign bus.BP_target_pc = w_bpTarget;

   // Hit detection and saturating counter steps for the entry being trained.
   always_comb begin
      w_whit   = r_valid[w_widx] && (r_tag[w_widx] == w_wtag);
      w_ctrCur = r_ctr[w_widx];
      w_ctrInc = w_ctrCur;
      w_ctrDec = w_ctrCur;
      if (w_ctrCur != CTR_STRONG_T) begin
         w_ctrInc = w_ctrCur + 2'b01;
      end
      if (w_ctrCur != CTR_STRONG_NT) begin
         w_ctrDec = w_ctrCur - 2'b01;
      end
   end

   // Table training: strengthen or weaken a hitting entry, and allocate or
   // replace the entry only on a taken miss. JAL/JALR arrive as taken, so a
   // changed JALR target simply overwrites the stored target on a hit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= CTR_WEAK_NT;
         end
      end else if (w_upd) begin
         if (w_whit) begin
            if (bus.E_Branch_taken) begin
               r_ctr[w_widx]    <= w_ctrInc;
               r_target[w_widx] <= bus.EXE_target_pc;
            end else begin
               r_ctr[w_widx]    <= w_ctrDec;
            end
         end else if (bus.E_Branch_taken) begin
            r_valid[w_widx]  <= 1'b1;
            r_tag[w_widx]    <= w_wtag;
            r_target[w_widx] <= bus.EXE_target_pc;
            r_ctr[w_widx]    <= CTR_WEAK_T;
         end
      end
   end

   // Perf counters count each resolved instruction and each mispredict
   // flush once, sticking at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_brCnt   <= '0;
         r_missCnt <= '0;
      end else if (w_upd) begin
         if (r_brCnt != '1) begin
            r_brCnt <= r_brCnt + 1'b1;
         end
         if (bus.Flush && (r_missCnt != '1)) begin
            r_missCnt <= r_missCnt + 1'b1;
         end
      end
   end

   assign bus.br_cnt   = r_brCnt;
   assign bus.miss_cnt = r_missCnt;

endmodule
